// File: rtl/pdecode_pkg.sv
// Shared definitions for the pdecode_pulse block: FSM state encoding,
// default code width, counter width and a small length helper.
package pdecode_pkg;

  // Default code width and matching one-hot width.
  localparam int W_DFLT  = 3;
  localparam int N       = 2 ** W_DFLT;

  // Pulse/gap counter width and the longest length it can express.
  localparam int CNT_W   = 8;
  localparam int LEN_MAX = (2 ** CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  // Counter preload for a phase lasting len cycles (counts down to zero).
  function automatic cnt_t len_to_cnt(input int len);
    return cnt_t'(len - 1);
  endfunction

endpackage

// File: rtl/pdecode_if.sv
// Code handshake between an encoder (master) and pdecode_pulse (slave).
interface pdecode_if
  import pdecode_pkg::*;
#(
  parameter int W = W_DFLT
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] code;

  modport master (
    output in_valid,
    output code,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  code,
    output in_ready
  );

endinterface

// File: rtl/pdecode_core.sv
// Pure combinational W-to-2**W decoder: drives the single line selected by code.
module pdecode_core
  import pdecode_pkg::*;
#(
  parameter int W = W_DFLT
) (
  input  logic [W-1:0]      code,
  output logic [2**W-1:0]   onehot
);

  localparam int NO = 2 ** W;

  // Shift a single set bit up to the selected line.
  always_comb begin
    onehot = {{(NO-1){1'b0}}, 1'b1} << code;
  end

endmodule

// File: rtl/pdecode_pulse.sv
// Re-expands an accepted code into a one-hot strobe held for PULSE_LEN
// cycles, followed by GAP_LEN forced idle cycles. Also keeps a sticky
// per-line seen register and a wrapping count of accepted codes.
module pdecode_pulse
  import pdecode_pkg::*;
#(
  parameter int W         = W_DFLT,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  pdecode_if.slave          in_if,
  output logic [2**W-1:0]   y,
  output logic              busy,
  output logic [2**W-1:0]   seen,
  input  logic [2**W-1:0]   seen_clr,
  output logic [CNT_W-1:0]  acc_cnt
);

  localparam int NO = 2 ** W;

  localparam cnt_t PULSE_INIT = len_to_cnt(PULSE_LEN);
  localparam cnt_t GAP_INIT   = len_to_cnt((GAP_LEN > 0) ? GAP_LEN : 1);

  // Lengths outside the counter range cannot be represented; stop elaboration.
  if ((PULSE_LEN < 1) || (PULSE_LEN > LEN_MAX)) begin : g_bad_pulse_len
    $error("pdecode_pulse: PULSE_LEN must be in 1..%0d", LEN_MAX);
  end
  if ((GAP_LEN < 0) || (GAP_LEN > LEN_MAX)) begin : g_bad_gap_len
    $error("pdecode_pulse: GAP_LEN must be in 0..%0d", LEN_MAX);
  end

  state_e           state_q, state_d;
  cnt_t             cnt_q,   cnt_d;
  logic [NO-1:0]    y_q,     y_d;
  logic [NO-1:0]    seen_q,  seen_d;
  logic [CNT_W-1:0] acc_q,   acc_d;

  logic [NO-1:0]    dec_line;
  logic             accept;

  pdecode_core #(.W(W)) u_core (
    .code   (in_if.code),
    .onehot (dec_line)
  );

  // Ready is purely combinational so a reset cycle never accepts.
  assign in_if.in_ready = (state_q == ST_IDLE) && en && !rst;
  assign accept         = in_if.in_valid && in_if.in_ready;

  // Next-state, pulse counter, output line, sticky seen and accept count.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    acc_d   = acc_q;
    seen_d  = seen_q & ~seen_clr;

    unique case (state_q)
      ST_IDLE: begin
        y_d = '0;
        if (accept) begin
          y_d     = dec_line;
          cnt_d   = PULSE_INIT;
          state_d = ST_ACTIVE;
          // Applied after the clear so a same-cycle set beats a clear.
          seen_d  = seen_d | dec_line;
          acc_d   = acc_q + 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          y_d = '0;
          if (GAP_LEN > 0) begin
            cnt_d   = GAP_INIT;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        y_d = '0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        y_d     = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      seen_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      seen_q  <= seen_d;
      acc_q   <= acc_d;
    end
  end

  assign y       = y_q;
  assign busy    = (state_q != ST_IDLE);
  assign seen    = seen_q;
  assign acc_cnt = acc_q;

endmodule

// File: tb/tb_pdecode_pulse.sv
// Self-checking bench for pdecode_pulse. Two instances share the stimulus:
// dut 0 with GAP_LEN=1, dut 1 with GAP_LEN=0. The reference model tracks
// each accept as a timeline (pulse end cycle, ready-again cycle) instead
// of a state machine.
module tb_pdecode_pulse;
  import pdecode_pkg::*;

  localparam int TW = 3;
  localparam int TN = 8;
  localparam int P  = 4;
  localparam int GAPS [2] = '{1, 0};

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [TW-1:0] code;
  logic [TN-1:0] seen_clr;

  logic [TN-1:0] y_a, y_b, seen_a, seen_b;
  logic          busy_a, busy_b;
  logic [7:0]    acc_a, acc_b;

  logic [TN-1:0] y_w    [2];
  logic [TN-1:0] seen_w [2];
  logic          busy_w [2];
  logic [7:0]    acc_w  [2];
  logic          rdy_w  [2];

  pdecode_if #(.W(TW)) if_a ();
  pdecode_if #(.W(TW)) if_b ();

  assign if_a.in_valid = in_valid;
  assign if_a.code     = code;
  assign if_b.in_valid = in_valid;
  assign if_b.code     = code;

  pdecode_pulse #(.W(TW), .PULSE_LEN(P), .GAP_LEN(1)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_if    (if_a),
    .y        (y_a),
    .busy     (busy_a),
    .seen     (seen_a),
    .seen_clr (seen_clr),
    .acc_cnt  (acc_a)
  );

  pdecode_pulse #(.W(TW), .PULSE_LEN(P), .GAP_LEN(0)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_if    (if_b),
    .y        (y_b),
    .busy     (busy_b),
    .seen     (seen_b),
    .seen_clr (seen_clr),
    .acc_cnt  (acc_b)
  );

  assign y_w[0]    = y_a;     assign y_w[1]    = y_b;
  assign seen_w[0] = seen_a;  assign seen_w[1] = seen_b;
  assign busy_w[0] = busy_a;  assign busy_w[1] = busy_b;
  assign acc_w[0]  = acc_a;   assign acc_w[1]  = acc_b;
  assign rdy_w[0]  = if_a.in_ready;
  assign rdy_w[1]  = if_b.in_ready;

  always #5 clk = ~clk;

  // Reference model: cycle index and per-dut timeline.
  int            cyc;
  int            ready_from [2];
  int            pulse_last [2];
  int            code_m     [2];
  logic [TN-1:0] seen_m     [2];
  int            acc_m      [2];
  int            total_m    [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic m_busy(input int d);
    return cyc < ready_from[d];
  endfunction

  function automatic logic [TN-1:0] m_y(input int d);
    logic [TN-1:0] one;
    one = 1;
    return (cyc <= pulse_last[d]) ? (one << code_m[d]) : '0;
  endfunction

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic step();
    logic acc_now [2];
    logic m_rdy;
    #1;
    for (int d = 0; d < 2; d++) begin
      m_rdy = !m_busy(d) && en && !rst;
      check($sformatf("in_ready[%0d]", d), 32'(rdy_w[d]), 32'(m_rdy));
      acc_now[d] = in_valid && m_rdy;
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ready_from[d] = cyc;
        pulse_last[d] = -1;
        seen_m[d]     = '0;
        acc_m[d]      = 0;
      end else begin
        seen_m[d] = seen_m[d] & ~seen_clr;
        if (acc_now[d]) begin
          code_m[d]     = int'(code);
          pulse_last[d] = cyc + P - 1;
          ready_from[d] = cyc + P + GAPS[d];
          seen_m[d][code] = 1'b1;
          acc_m[d]      = (acc_m[d] + 1) % 256;
          total_m[d]++;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("y[%0d]", d),    32'(y_w[d]),    32'(m_y(d)));
      check($sformatf("busy[%0d]", d), 32'(busy_w[d]), 32'(m_busy(d)));
      check($sformatf("seen[%0d]", d), 32'(seen_w[d]), 32'(seen_m[d]));
      check($sformatf("acc[%0d]", d),  32'(acc_w[d]),  32'(acc_m[d]));
      check($sformatf("onehot[%0d]", d), 32'($countones(y_w[d]) <= 1), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      ready_from[d] = 0;
      pulse_last[d] = -1;
      code_m[d]     = 0;
      seen_m[d]     = '0;
      acc_m[d]      = 0;
      total_m[d]    = 0;
    end
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; code = '0; seen_clr = '0;

    // Reset state.
    do_reset();
    do_reset();

    // Single accept of code 5.
    en = 1'b1; in_valid = 1'b1; code = 3'd5;
    step();
    in_valid = 1'b0;
    check("first_pulse_y", 32'(y_a), 32'h20);
    idle(8);
    check("first_seen", 32'(seen_a), 32'h20);
    check("first_acc",  32'(acc_a),  32'd1);

    // Back-to-back codes 0..7 with in_valid held.
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int g = 0; g < 100 && acc_m[1] < 8; g++) begin
      code = TW'(acc_m[1] % 8);
      step();
    end
    in_valid = 1'b0;
    check("sweep_seen_b", 32'(seen_b), 32'hFF);
    check("sweep_acc_b",  32'(acc_b),  32'd8);
    idle(8);

    // Reset during ACTIVE with code 3.
    in_valid = 1'b1; code = 3'd3;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_y",    32'(y_a),    32'd0);
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    check("rst_mid_seen", 32'(seen_a), 32'd0);
    check("rst_mid_acc",  32'(acc_a),  32'd0);
    idle(2);

    // Same-cycle set and clear: set wins.
    in_valid = 1'b1; code = 3'd3;
    step();
    idle(8);
    check("seen_pre", 32'(seen_a), 32'h08);
    in_valid = 1'b1; code = 3'd3; seen_clr = 8'h09;
    step();
    in_valid = 1'b0; seen_clr = '0;
    check("seen_set_wins", 32'(seen_a), 32'h08);
    idle(8);
    seen_clr = 8'h08;
    step();
    seen_clr = '0;
    check("seen_cleared", 32'(seen_a), 32'h00);

    // en low blocks accepts; dropping en mid-pulse keeps the pulse.
    en = 1'b0; in_valid = 1'b1; code = 3'd6;
    repeat (6) step();
    check("en_low_acc", 32'(acc_a), 32'd2);
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (3) step();
    check("en_drop_y", 32'(y_a), 32'h40);
    idle(6);
    en = 1'b1;

    // Long run to wrap the accept counter.
    do_reset();
    total_m[0] = 0; total_m[1] = 0;
    en = 1'b1; in_valid = 1'b1;
    repeat (1600) begin
      code     = TW'($urandom_range(0, TN - 1));
      seen_clr = ($urandom_range(0, 7) == 0) ? TN'($urandom) : '0;
      step();
    end
    seen_clr = '0;
    check("wrap_total_a", 32'(total_m[0] >= 256), 32'd1);
    check("wrap_acc_a",   32'(acc_a), 32'(total_m[0] % 256));
    check("wrap_acc_b",   32'(acc_b), 32'(total_m[1] % 256));

    // Fully random traffic including rare resets.
    repeat (500) begin
      rst      = ($urandom_range(0, 40) == 0);
      en       = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      code     = TW'($urandom_range(0, TN - 1));
      seen_clr = ($urandom_range(0, 5) == 0) ? TN'($urandom) : '0;
      step();
    end
    rst = 1'b0;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdecode_pulse.md
Name: pdecode_pulse

Overview:
- Decoder end of the 8-to-3 priority-encoder path. Accepts a 3-bit code through a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles, followed by an enforced idle gap.
- Keeps a sticky per-line "seen" status and a wrapping accept counter for software and bench visibility.
- Sits downstream of pencode, so encoded requests can be re-expanded into one-hot strobes.

Parameters:
- W, 3: code width; one-hot output width is 2**W (8 by default).
- PULSE_LEN, 4: cycles the one-hot output is held, legal range 1..255.
- GAP_LEN, 1: forced idle cycles after each pulse, legal range 0..255.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  accept enable; it gates in_ready only.
- in_valid  input  1  code is presented.
- in_ready  output  1  block can accept a code this cycle.
- code  input  W  encoded line index.
- y  output  2**W  registered one-hot pulse output.
- busy  output  1  high whenever state is not IDLE.
- seen  output  2**W  sticky record of lines pulsed since the last clear.
- seen_clr  input  2**W  per-bit clear of seen, one-cycle strobe.
- acc_cnt  output  8  count of accepted codes, wraps.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, cnt=0.
  - y=0, seen=0, acc_cnt=0, busy=0.
  - in_ready follows combinationally: it is 0 while rst is high.
  - Reset mid-pulse or mid-gap aborts immediately; y is 0 on the next cycle.
- in_ready:
  - Combinational: (state==IDLE) && en && !rst.
  - Accept = in_valid && in_ready at a rising edge.
  - code is sampled only on accept; changes at other times are ignored.
- State machine: IDLE, ACTIVE, GAP.
  - IDLE, on accept: y <= 1<<code, cnt <= PULSE_LEN-1, move to ACTIVE, seen[code] <= 1, acc_cnt <= acc_cnt+1 (255 wraps to 0).
  - ACTIVE, cnt!=0: hold y, cnt <= cnt-1.
  - ACTIVE, cnt==0: y <= 0. If GAP_LEN>0, cnt <= GAP_LEN-1 and move to GAP; otherwise move to IDLE.
  - GAP: y=0. If cnt!=0, cnt <= cnt-1; if cnt==0, move to IDLE.
- Latency:
  - An accept at edge k gives y one-hot during cycles k+1..k+PULSE_LEN.
  - in_ready is high again in cycle k+PULSE_LEN+GAP_LEN+1.
  - With GAP_LEN=0, back-to-back pulses are separated by exactly one IDLE cycle with y=0.
- y invariants: y is always either zero or exactly one-hot; it never changes value within a pulse.
- en:
  - Dropping en mid-pulse does not shorten the pulse or the gap.
  - en only blocks new accepts.
- seen:
  - Bit i clears when seen_clr[i]=1.
  - A set and a clear of the same bit in the same cycle: set wins.
  - Clears of other bits in that cycle are unaffected.
- Counter width: cnt is 8 bits. Parameters outside the legal ranges are a synthesis-time error (generate-time check).

Decomposition:
- Shared package pdecode_pkg holds:
  - the state encoding (IDLE=2'd0, ACTIVE=2'd1, GAP=2'd2);
  - localparam N=2**W;
  - the counter width constant (8).
- One natural sub-module, pdecode_core: a purely combinational 3-to-8 (W-to-2**W) decoder producing 1<<code, reused by the register stage.
- FSM, counters and sticky register stay in the top module.

Test Plan:
- After rst, drive code=3'd5 with in_valid=1 and en=1 (PULSE_LEN=4, GAP_LEN=1) -> y=8'b0010_0000 for exactly 4 cycles, then 1 gap cycle with y=0. in_ready returns 1 six cycles after accept. seen=8'h20, acc_cnt=1.
- Hold in_valid=1 continuously, cycling code 0..7 with GAP_LEN=0 -> each code yields a 4-cycle pulse of 1<<code with one y=0 cycle between pulses. Final seen=8'hFF, acc_cnt=8.
- Assert rst during ACTIVE, cnt=2, code=3'd3 -> next cycle y=0, busy=0, seen=0, acc_cnt=0. in_ready=1 once rst drops and en=1.
- With seen=8'h08 and a fresh accept of code=3 in the same cycle as seen_clr=8'h09 -> seen=8'h08 (set wins on bit 3, bit 0 already 0). A later seen_clr=8'h08 alone -> seen=0.
- en=0 with in_valid=1 -> in_ready=0, y stays 0, acc_cnt unchanged. Drop en mid-pulse -> pulse still lasts PULSE_LEN cycles.
- Perform 256 accepts -> acc_cnt wraps to 0. Compare against a reference model after every edge: y must be zero or one-hot.
